itype_detector_multi: RTL and testbench
=======================================

Name: itype_detector_multi

Overview:
- Multi-retire, registered successor to the single-port instruction-type detector.
- Classifies up to NRET committed instructions per cycle into mure_pkg::itype_e values for the trace encoder.
- Supports 3-bit and 4-bit itype modes. The 4-bit mode classifies call, tail-call, return and co-routine swap.
- Adds pipelined valid/ready output, squashing of slots younger than an exception, sticky interrupt tracking and standalone interrupt emission.

Parameters:
- NRET, 2, number of commit channels (1..4).
- ITYPE_LEN, mure_pkg::ITYPE_LEN, itype width: 3 or 4. Any other value is an elaboration error.
- INT_TIMEOUT, 8, idle cycles before a pending interrupt is emitted standalone. 0 disables standalone emission.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- valid_i  in  NRET  committed instruction present per slot; slot 0 is oldest
- exception_i  in  NRET  slot raised an exception
- interrupt_i  in  1  interrupt taken; no committed instruction required
- op_i  in  NRET x mure_pkg::fu_op  functional-unit op per slot
- branch_taken_i  in  NRET  branch resolved taken
- rd_i  in  NRET x 5  destination register index
- rs1_i  in  NRET x 5  source register 1 index
- ready_o  out  1  group can be accepted
- valid_o  out  NRET  output slot valid
- itype_o  out  NRET x mure_pkg::itype_e  per-slot type
- ready_i  in  1  encoder consumes output group
- int_pending_o  out  1  interrupt latched, not yet reported

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is synchronous and active-low.
- Reset values: valid_o=0, itype_o=STD for all slots, int_pending_o=0, idle counter=0, output register empty, ready_o=1.
  - Reset asserted mid-operation discards the held group and the pending interrupt.
- Handshake:
  - ready_o = ~out_full | ready_i.
  - A group is accepted when ready_o && |valid_i.
  - Latency is one cycle: the accepted group appears on valid_o/itype_o in the next cycle.
  - While out_full && ~ready_i, the outputs hold stable and inputs are ignored. Upstream must hold its inputs.
  - If ready_i is high and no new group is loaded, valid_o clears the next cycle.
- Per-slot priority (k = slot):
  - EXC if exception_i[k].
  - Else INT, if k is the interrupt slot (see Interrupt).
  - Else ERET if op is MRET, SRET or DRET.
  - Else NTB if BRANCH and not taken.
  - Else TB if BRANCH and taken.
  - Else a jump type (see mode rules).
  - Else STD.
- 3-bit mode: JALR -> UIJ. JAL -> STD.
- 4-bit mode: link(r) means r in {1,5}.
  - JALR, with rd link and rs1 link and rd!=rs1 -> co-routine swap.
  - JALR, else with rd link -> uninferable call.
  - JALR, else with rs1 link -> return.
  - JALR, else with rd==0 -> uninferable tail-call.
  - JALR, otherwise -> other uninferable jump.
  - JAL with rd link -> inferable call.
  - JAL with rd==0 -> inferable tail-call.
  - JAL, otherwise -> other inferable jump.
- Exception squash:
  - Slots with an index above the lowest valid slot that has exception_i set get valid_o=0 and itype_o=STD.
  - The exception slot itself is reported.
- Interrupt:
  - interrupt_i sets int_pending.
  - On an accepted group, the interrupt slot is the highest valid, unsquashed slot, evaluated with interrupt_i OR int_pending.
  - If that slot has EXC, the exception is reported and the interrupt stays pending.
  - Otherwise the slot is reported as INT and pending clears.
  - An interrupt_i arriving in the same cycle as it is consumed coalesces with it; pending does not re-set.
  - Multiple interrupts before consumption coalesce into one.
- Standalone interrupt:
  - The idle counter increments each cycle while pending && no group is accepted. It saturates at INT_TIMEOUT.
  - It resets on acceptance or when pending clears.
  - When counter==INT_TIMEOUT && ready_o, the output loads valid_o=...0001 with itype_o[0]=INT. Pending and the counter then clear.
  - If |valid_i is high in the same cycle, the group takes precedence.
- Types not defined in 3-bit mode are never emitted.

Decomposition:
- mure_pkg additions:
  - itype_e values for 4-bit mode: UCALL=8, ICALL=9, UTAIL=10, ITAIL=11, COSWAP=12, RET=13, OUIJ=14, OIJ=15.
  - Constant LINK_X1=1, LINK_X5=5.
  - Function is_link.
- One sub-module: itype_classify. It is the combinational per-slot classifier covering op, branch, rd, rs1, exception, int_here and mode, instantiated NRET times.
- The top level holds the handshake register, squash logic, interrupt latch and counter.

Test Plan:
- NRET=2, ITYPE_LEN=3, slot0 BRANCH taken, slot1 JALR, ready_i=1 -> next cycle valid_o=11, itype_o={UIJ,TB}.
- ITYPE_LEN=4, slot0 JALR rd=1 rs1=5, slot1 JAL rd=0 -> {ITAIL,COSWAP}. Slot0 JALR rd=0 rs1=1 -> RET.
- Slot0 exception_i=1 with slot1 valid -> valid_o=01, itype_o[0]=EXC. Same group with interrupt_i=1 -> EXC reported, int_pending_o stays 1.
- interrupt_i pulse, no valid_i, INT_TIMEOUT=8 -> after 8 idle cycles valid_o=01, itype_o[0]=INT, int_pending_o=0.
- Output held, ready_i=0 for 3 cycles -> ready_o=0 and outputs unchanged. ready_i=1 with a new group -> back-to-back load, no bubble.
- rst_ni=0 while the output is held and an interrupt is pending -> next cycle valid_o=0, int_pending_o=0, ready_o=1.

Source files
------------

// File: rtl/mure_pkg.sv
// Shared types for the trace front end: itype codes,
// functional-unit ops and link-register helpers.
package mure_pkg;

    // Default itype width for the trace encoder (3 or 4).
    localparam int ITYPE_LEN = 3;

    // Registers treated as link registers for call/return inference.
    localparam logic [4:0] LINK_X1 = 5'd1;
    localparam logic [4:0] LINK_X5 = 5'd5;

    // Values 0..7 are shared by both modes; 8..15 exist only
    // in 4-bit mode and replace UIJ for jumps.
    typedef enum logic [3:0] {
        STD    = 4'd0,
        EXC    = 4'd1,
        INT    = 4'd2,
        ERET   = 4'd3,
        NTB    = 4'd4,
        TB     = 4'd5,
        UIJ    = 4'd6,
        RSVD   = 4'd7,
        UCALL  = 4'd8,
        ICALL  = 4'd9,
        UTAIL  = 4'd10,
        ITAIL  = 4'd11,
        COSWAP = 4'd12,
        RET    = 4'd13,
        OUIJ   = 4'd14,
        OIJ    = 4'd15
    } itype_e;

    typedef enum logic [3:0] {
        ADD    = 4'd0,
        BRANCH = 4'd1,
        JAL    = 4'd2,
        JALR   = 4'd3,
        MRET   = 4'd4,
        SRET   = 4'd5,
        DRET   = 4'd6
    } fu_op;

    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_X1) || (r == LINK_X5);
    endfunction

endpackage

// File: rtl/itype_detector_multi_classify.sv
// Combinational per-slot itype classifier.
// Ports: op/branch/rd/rs1/exception/int_here in, itype_o out.
module itype_classify
    import mure_pkg::*;
#(
    parameter int ITYPE_LEN = mure_pkg::ITYPE_LEN
) (
    input  fu_op       op_i,
    input  logic       branch_taken_i,
    input  logic [4:0] rd_i,
    input  logic [4:0] rs1_i,
    input  logic       exception_i,
    input  logic       int_here_i,
    output itype_e     itype_o
);

    logic   w_rdl;
    logic   w_rsl;
    itype_e w_jmp;

    always_comb begin
        w_rdl = is_link(rd_i);
        w_rsl = is_link(rs1_i);
        w_jmp = STD;
        if (ITYPE_LEN == 3) begin
            if (op_i == JALR) w_jmp = UIJ;
        end else begin
            unique case (op_i)
                JALR: begin
                    if (w_rdl && w_rsl && (rd_i != rs1_i))
                        w_jmp = COSWAP;
                    else if (w_rdl)
                        w_jmp = UCALL;
                    else if (w_rsl)
                        w_jmp = RET;
                    else if (rd_i == 5'd0)
                        w_jmp = UTAIL;
                    else
                        w_jmp = OUIJ;
                end
                JAL: begin
                    if (w_rdl)
                        w_jmp = ICALL;
                    else if (rd_i == 5'd0)
                        w_jmp = ITAIL;
                    else
                        w_jmp = OIJ;
                end
                default: w_jmp = STD;
            endcase
        end
    end

    always_comb begin
        itype_o = STD;
        if (exception_i)
            itype_o = EXC;
        else if (int_here_i)
            itype_o = INT;
        else if (op_i inside {MRET, SRET, DRET})
            itype_o = ERET;
        else if (op_i == BRANCH)
            itype_o = branch_taken_i ? TB : NTB;
        else
            itype_o = w_jmp;
    end

endmodule

// File: rtl/itype_detector_multi.sv
// Multi-retire registered itype detector with valid/ready output.
// Ports: clk_i, rst_ni, per-slot commit inputs, ready_o,
// valid_o/itype_o group output, ready_i, int_pending_o.
module itype_detector_multi
    import mure_pkg::*;
#(
    parameter int NRET        = 2,
    parameter int ITYPE_LEN   = mure_pkg::ITYPE_LEN,
    parameter int INT_TIMEOUT = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NRET-1:0]                 valid_i,
    input  logic [NRET-1:0]                 exception_i,
    input  logic                            interrupt_i,
    input  fu_op [NRET-1:0]                 op_i,
    input  logic [NRET-1:0]                 branch_taken_i,
    input  logic [NRET-1:0][4:0]            rd_i,
    input  logic [NRET-1:0][4:0]            rs1_i,
    output logic                            ready_o,
    output logic [NRET-1:0]                 valid_o,
    output logic [NRET-1:0][ITYPE_LEN-1:0]  itype_o,
    input  logic                            ready_i,
    output logic                            int_pending_o
);

    if (!(ITYPE_LEN == 3 || ITYPE_LEN == 4)) begin : g_bad_len
        $error("itype_detector_multi: ITYPE_LEN must be 3 or 4");
    end
    if (NRET < 1 || NRET > 4) begin : g_bad_nret
        $error("itype_detector_multi: NRET must be 1..4");
    end

    localparam int CW = (INT_TIMEOUT > 0) ? $clog2(INT_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(INT_TIMEOUT);
    localparam logic [ITYPE_LEN-1:0] L_INT = ITYPE_LEN'(INT);

    logic                           r_full;
    logic [NRET-1:0]                r_valid;
    logic [NRET-1:0][ITYPE_LEN-1:0] r_itype;
    logic                           r_pend;
    logic [CW-1:0]                  r_cnt;

    logic [NRET-1:0]                w_squash;
    logic                           w_seen;
    logic [NRET-1:0]                w_vld;
    logic [NRET-1:0]                w_int_here;
    logic [$clog2(NRET+1)-1:0]      w_top;
    logic                           w_int_req;
    logic                           w_int_exc;
    logic                           w_accept;
    logic                           w_int_take;
    logic                           w_fire;
    logic [3:0]                     w_cls [NRET];
    logic [NRET-1:0][ITYPE_LEN-1:0] w_it_nx;
    logic                           w_pend_nx;
    logic [CW-1:0]                  w_cnt_nx;

    assign ready_o       = ~r_full | ready_i;
    assign valid_o       = r_valid;
    assign itype_o       = r_itype;
    assign int_pending_o = r_pend;

    assign w_accept  = ready_o & (|valid_i);
    assign w_int_req = interrupt_i | r_pend;

    // Everything younger than the oldest excepting slot is dropped.
    always_comb begin
        w_squash = '0;
        w_seen   = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            if (w_seen)
                w_squash[k] = 1'b1;
            else if (valid_i[k] && exception_i[k])
                w_seen = 1'b1;
        end
    end

    assign w_vld = valid_i & ~w_squash;

    // Interrupt attaches to the youngest surviving slot.
    always_comb begin
        w_top      = '0;
        w_int_here = '0;
        for (int k = 0; k < NRET; k++) begin
            if (w_vld[k]) w_top = ($clog2(NRET+1))'(k);
        end
        if (w_int_req && (|w_vld))
            w_int_here[w_top] = 1'b1;
    end

    assign w_int_exc  = |(w_int_here & exception_i);
    assign w_int_take = w_accept & (|w_int_here) & ~w_int_exc;

    assign w_fire = (INT_TIMEOUT != 0) && r_pend &&
                    (r_cnt == TMO) && ready_o && !(|valid_i);

    for (genvar k = 0; k < NRET; k++) begin : g_cls
        itype_e w_c;
        itype_classify #(
            .ITYPE_LEN (ITYPE_LEN)
        ) u_cls (
            .op_i           (op_i[k]),
            .branch_taken_i (branch_taken_i[k]),
            .rd_i           (rd_i[k]),
            .rs1_i          (rs1_i[k]),
            .exception_i    (exception_i[k]),
            .int_here_i     (w_int_here[k]),
            .itype_o        (w_c)
        );
        assign w_cls[k] = w_c;
    end

    always_comb begin
        for (int k = 0; k < NRET; k++) begin
            w_it_nx[k] = w_vld[k] ? w_cls[k][ITYPE_LEN-1:0] : '0;
        end
    end

    // An interrupt_i in the consuming cycle merges with the one taken.
    always_comb begin
        w_pend_nx = r_pend;
        if (w_int_take || w_fire)
            w_pend_nx = 1'b0;
        else if (interrupt_i)
            w_pend_nx = 1'b1;
    end

    always_comb begin
        w_cnt_nx = r_cnt;
        if (w_accept || w_fire || !r_pend)
            w_cnt_nx = '0;
        else if (r_cnt != TMO)
            w_cnt_nx = r_cnt + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_full  <= 1'b0;
            r_valid <= '0;
            r_itype <= '0;
            r_pend  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_pend <= w_pend_nx;
            r_cnt  <= w_cnt_nx;
            if (ready_o) begin
                if (w_accept) begin
                    r_full  <= 1'b1;
                    r_valid <= w_vld;
                    r_itype <= w_it_nx;
                end else if (w_fire) begin
                    r_full     <= 1'b1;
                    r_valid    <= NRET'(1);
                    r_itype    <= '0;
                    r_itype[0] <= L_INT;
                end else begin
                    r_full  <= 1'b0;
                    r_valid <= '0;
                    r_itype <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_itype_detector_multi.sv
// Directed bench for itype_detector_multi in 3-bit and 4-bit modes.
// Table vectors plus hand sequences for multi-cycle behaviour.
module tb_itype_detector_multi;
    import mure_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      valid_i;
    logic [1:0]      exc_i;
    logic            intr_i;
    fu_op [1:0]      op_i;
    logic [1:0]      tk_i;
    logic [1:0][4:0] rd_i;
    logic [1:0][4:0] rs1_i;
    logic            ready_i;

    logic            rdy3, rdy4;
    logic [1:0]      v3, v4;
    logic [1:0][2:0] it3;
    logic [1:0][3:0] it4;
    logic            p3, p4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    itype_detector_multi #(
        .NRET(2), .ITYPE_LEN(3), .INT_TIMEOUT(8)
    ) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i),
        .exception_i(exc_i), .interrupt_i(intr_i), .op_i(op_i),
        .branch_taken_i(tk_i), .rd_i(rd_i), .rs1_i(rs1_i),
        .ready_o(rdy3), .valid_o(v3), .itype_o(it3),
        .ready_i(ready_i), .int_pending_o(p3)
    );

    itype_detector_multi #(
        .NRET(2), .ITYPE_LEN(4), .INT_TIMEOUT(8)
    ) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i),
        .exception_i(exc_i), .interrupt_i(intr_i), .op_i(op_i),
        .branch_taken_i(tk_i), .rd_i(rd_i), .rs1_i(rs1_i),
        .ready_o(rdy4), .valid_o(v4), .itype_o(it4),
        .ready_i(ready_i), .int_pending_o(p4)
    );

    typedef struct {
        logic [1:0] v;
        logic [1:0] e;
        fu_op       op0;
        fu_op       op1;
        logic [1:0] tk;
        logic [4:0] rd0;
        logic [4:0] rs0;
        logic [4:0] rd1;
        logic [4:0] rs1;
        logic [1:0] ev;
        itype_e     a0;
        itype_e     a1;
        itype_e     b0;
        itype_e     b1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [1:0] v, input logic [1:0] e,
        input fu_op op0, input fu_op op1, input logic [1:0] tk,
        input int rd0, input int rs0, input int rd1, input int rs1,
        input logic [1:0] ev,
        input itype_e a0, input itype_e a1,
        input itype_e b0, input itype_e b1);
        vec_t x;
        x.v = v; x.e = e; x.op0 = op0; x.op1 = op1; x.tk = tk;
        x.rd0 = 5'(rd0); x.rs0 = 5'(rs0);
        x.rd1 = 5'(rd1); x.rs1 = 5'(rs1);
        x.ev = ev; x.a0 = a0; x.a1 = a1; x.b0 = b0; x.b1 = b1;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        valid_i  = x.v;
        exc_i    = x.e;
        op_i[0]  = x.op0;
        op_i[1]  = x.op1;
        tk_i     = x.tk;
        rd_i[0]  = x.rd0;
        rs1_i[0] = x.rs0;
        rd_i[1]  = x.rd1;
        rs1_i[1] = x.rs1;
    endtask

    task automatic idle();
        valid_i = 2'b00;
        exc_i   = 2'b00;
        op_i[0] = ADD;
        op_i[1] = ADD;
        tk_i    = 2'b00;
        rd_i    = '0;
        rs1_i   = '0;
    endtask

    task automatic chk_vec(input string nm, input vec_t x);
        chk({nm, " v3"}, 8'(v3), 8'(x.ev));
        chk({nm, " v4"}, 8'(v4), 8'(x.ev));
        chk({nm, " it3[0]"}, 8'(it3[0]), 8'(x.a0));
        chk({nm, " it3[1]"}, 8'(it3[1]), 8'(x.a1));
        chk({nm, " it4[0]"}, 8'(it4[0]), 8'(x.b0));
        chk({nm, " it4[1]"}, 8'(it4[1]), 8'(x.b1));
    endtask

    initial begin
        int n;
        vec_t g;
        tbl.push_back(mk(2'b11, 2'b00, BRANCH, JALR, 2'b01,
                         0, 0, 0, 6, 2'b11, TB, UIJ, TB, UTAIL));
        tbl.push_back(mk(2'b11, 2'b00, JALR, JAL, 2'b00,
                         1, 5, 0, 0, 2'b11, UIJ, STD, COSWAP, ITAIL));
        tbl.push_back(mk(2'b11, 2'b00, JALR, BRANCH, 2'b00,
                         0, 1, 0, 0, 2'b11, UIJ, NTB, RET, NTB));
        tbl.push_back(mk(2'b11, 2'b00, JALR, JAL, 2'b00,
                         5, 5, 1, 0, 2'b11, UIJ, STD, UCALL, ICALL));
        tbl.push_back(mk(2'b11, 2'b00, JALR, JAL, 2'b00,
                         3, 7, 2, 0, 2'b11, UIJ, STD, OUIJ, OIJ));
        tbl.push_back(mk(2'b11, 2'b00, MRET, SRET, 2'b00,
                         0, 0, 0, 0, 2'b11, ERET, ERET, ERET, ERET));
        tbl.push_back(mk(2'b01, 2'b00, DRET, ADD, 2'b00,
                         0, 0, 0, 0, 2'b01, ERET, STD, ERET, STD));
        tbl.push_back(mk(2'b11, 2'b01, ADD, BRANCH, 2'b10,
                         0, 0, 0, 0, 2'b01, EXC, STD, EXC, STD));
        tbl.push_back(mk(2'b11, 2'b10, ADD, ADD, 2'b00,
                         0, 0, 0, 0, 2'b11, STD, EXC, STD, EXC));
        tbl.push_back(mk(2'b10, 2'b00, ADD, JALR, 2'b00,
                         0, 0, 1, 2, 2'b10, STD, UIJ, STD, UCALL));
        tbl.push_back(mk(2'b01, 2'b10, ADD, ADD, 2'b00,
                         0, 0, 0, 0, 2'b01, STD, STD, STD, STD));
        tbl.push_back(mk(2'b11, 2'b11, BRANCH, BRANCH, 2'b11,
                         0, 0, 0, 0, 2'b01, EXC, STD, EXC, STD));
        tbl.push_back(mk(2'b11, 2'b00, JAL, BRANCH, 2'b10,
                         1, 0, 0, 0, 2'b11, STD, TB, ICALL, TB));
        tbl.push_back(mk(2'b11, 2'b00, JALR, JALR, 2'b00,
                         1, 1, 0, 5, 2'b11, UIJ, UIJ, UCALL, RET));

        rst_n   = 1'b0;
        intr_i  = 1'b0;
        ready_i = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst v3", 8'(v3), 8'h0);
        chk("rst v4", 8'(v4), 8'h0);
        chk("rst it4", 8'(it4), 8'h0);
        chk("rst pend", 8'({p3, p4}), 8'h0);
        chk("rst ready", 8'({rdy3, rdy4}), 8'h3);

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            chk_vec($sformatf("vec%0d", i), tbl[i]);
        end
        idle();
        @(negedge clk);
        chk("drain v3", 8'(v3), 8'h0);
        chk("drain v4", 8'(v4), 8'h0);

        // Exception holds the interrupt pending; next group takes it.
        drive(tbl[7]);
        intr_i = 1'b1;
        @(negedge clk);
        intr_i = 1'b0;
        chk("excint v4", 8'(v4), 8'h1);
        chk("excint it3", 8'(it3[0]), 8'(EXC));
        chk("excint it4", 8'(it4[0]), 8'(EXC));
        chk("excint pend", 8'({p3, p4}), 8'h3);
        g = mk(2'b11, 2'b00, ADD, ADD, 2'b00, 0, 0, 0, 0,
               2'b11, STD, INT, STD, INT);
        drive(g);
        @(negedge clk);
        chk_vec("int take", g);
        chk("int take pend", 8'({p3, p4}), 8'h0);
        idle();
        @(negedge clk);

        // Standalone interrupt after the idle timeout.
        intr_i = 1'b1;
        @(negedge clk);
        intr_i = 1'b0;
        chk("sa pend", 8'({p3, p4}), 8'h3);
        chk("sa early v", 8'({v3, v4}), 8'h0);
        n = 0;
        while (n < 20 && v4 == 2'b00) begin
            @(negedge clk);
            n++;
        end
        chk("sa latency", 8'(n), 8'd9);
        chk("sa v3", 8'(v3), 8'h1);
        chk("sa v4", 8'(v4), 8'h1);
        chk("sa it3", 8'(it3[0]), 8'(INT));
        chk("sa it4", 8'(it4[0]), 8'(INT));
        chk("sa pend clr", 8'({p3, p4}), 8'h0);
        @(negedge clk);
        chk("sa clr v", 8'({v3, v4}), 8'h0);

        // Backpressure: outputs hold, then load without a bubble.
        drive(tbl[0]);
        @(negedge clk);
        chk_vec("hold load", tbl[0]);
        ready_i = 1'b0;
        drive(tbl[1]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d rdy", c),
                8'({rdy3, rdy4}), 8'h0);
            chk_vec($sformatf("hold%0d", c), tbl[0]);
        end
        ready_i = 1'b1;
        @(negedge clk);
        chk_vec("b2b 1", tbl[1]);
        drive(tbl[5]);
        @(negedge clk);
        chk_vec("b2b 2", tbl[5]);

        // Reset while holding with an interrupt pending.
        drive(tbl[7]);
        intr_i = 1'b1;
        @(negedge clk);
        intr_i  = 1'b0;
        ready_i = 1'b0;
        idle();
        @(negedge clk);
        chk("pre rst pend", 8'({p3, p4}), 8'h3);
        chk("pre rst v", 8'(v4), 8'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid rst v", 8'({v3, v4}), 8'h0);
        chk("mid rst pend", 8'({p3, p4}), 8'h0);
        chk("mid rst rdy", 8'({rdy3, rdy4}), 8'h3);
        chk("mid rst it", 8'({it3, it4}), 8'h0);
        rst_n   = 1'b1;
        ready_i = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
